mult_hilo_unit: RTL and testbench
=================================

Name: mult_hilo_unit

Overview:
- Multi-cycle multiplier in the EXE stage, beside the ALU. It takes the same val1/val2 operands from the ID/EXE register.
- It computes a 2*WORD_LEN-bit product by iterative shift-add and writes the result to HI/LO registers.
- It drives a stall to the hazard unit while busy.
- HI/LO read data (MFHI/MFLO) is muxed with aluOut ahead of the EXE/MEM register.

Parameters:
- WORD_LEN, 16, operand, HI and LO width (matches `WORD_LEN in defines.v).
- CNT_LEN, 5, width of the iteration counter; must satisfy 2^CNT_LEN > WORD_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  MULT issued in EXE this cycle; held high by upstream while stalled.
- is_signed  input  1  1 = two's-complement multiply, 0 = unsigned; sampled with start.
- val1  input  WORD_LEN  multiplicand.
- val2  input  WORD_LEN  multiplier.
- rd_sel  input  1  0 = read LO, 1 = read HI.
- rd_data  output  WORD_LEN  combinational HI or LO per rd_sel.
- hi  output  WORD_LEN  HI register.
- lo  output  WORD_LEN  LO register.
- stall  output  1  freeze IF/ID/EXE while the multiply is pending.
- done  output  1  one-cycle pulse when HI/LO has just been written.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: rst is sampled on the rising edge of clk only.
- On rst: state = IDLE, hi = 0, lo = 0, done = 0, counter = 0, internal accumulator = 0.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - When start = 1, latch the operands. If is_signed, latch the magnitudes of val1/val2 and store neg = val1[MSB] ^ val2[MSB]; otherwise latch raw values with neg = 0.
  - Clear the accumulator and counter, then go to BUSY.
  - When start = 0, stay in IDLE.
- BUSY, once per cycle:
  - If multiplier bit 0 = 1, add the multiplicand into the upper WORD_LEN+1 bits of the accumulator.
  - Shift the {carry, acc, multiplier} right by 1 and increment the counter.
  - On the edge where counter reaches WORD_LEN-1, write {hi, lo} = neg ? -product : product, then go to DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - start is ignored here, because the stalled MULT is still present on start in this cycle. Next state is IDLE unconditionally.
- stall is combinational: (state == IDLE && start) || state == BUSY. It is low in DONE so the pipeline advances.
- Latency:
  - start seen at edge E0, BUSY spans WORD_LEN edges, hi/lo are valid after edge E16 (WORD_LEN = 16).
  - done is high in the cycle after E16.
  - stall is high for 17 cycles in total.
- hi/lo hold their previous values throughout BUSY. rd_data during BUSY returns the old values; read hazards are the hazard unit's responsibility.
- Back-to-back MULT: the second MULT arrives in EXE while the unit is in IDLE (the cycle after DONE) and starts normally, with no lost or repeated operation.
- rst during BUSY or DONE: abort the operation, apply reset values, and do not update hi/lo with partial products.
- Arithmetic:
  - Accumulator is WORD_LEN+1 bits wide to hold the carry.
  - Signed negation is two's complement over the full 2*WORD_LEN bits.
  - Magnitude of -2^(WORD_LEN-1) is 2^(WORD_LEN-1), taken as unsigned and correct.

Decomposition:
- defines.v gains:
  - MULT_IDLE, MULT_BUSY and MULT_DONE state encodings (2 bits).
  - `HILO_SEL_LO = 0 and `HILO_SEL_HI = 1.
- The existing `EXE_MULT command code drives start in the EXE-stage glue.
- One natural sub-module: mult_datapath, holding the operand, accumulator and shift registers plus the counter. The parent keeps the FSM, the sign handling and the hi/lo registers.

Test Plan:
- Unsigned small product: start, is_signed = 0, val1 = 3, val2 = 5 -> stall high 17 cycles, then done pulse; hi = 0x0000, lo = 0x000F.
- Unsigned max: val1 = 0xFFFF, val2 = 0xFFFF, is_signed = 0 -> hi = 0xFFFE, lo = 0x0001. Then rd_sel = 1 -> rd_data = 0xFFFE.
- Signed: val1 = 0xFFFE (-2), val2 = 3, is_signed = 1 -> hi = 0xFFFF, lo = 0xFFFA. Also 0x8000 * 0x8000 signed -> hi = 0x4000, lo = 0x0000.
- start held high through DONE, then 7 * 9 issued the next cycle -> exactly two multiplies. Final hi = 0, lo = 0x003F; done pulses twice.
- rst asserted on the 6th BUSY cycle of 3 * 5, after a prior result of lo = 0x0011 -> hi/lo = 0, stall = 0, done = 0 on the next cycle; state IDLE.
- Read during BUSY: prior lo = 0x0011, new MULT running, rd_sel = 0 -> rd_data = 0x0011 until the done cycle, then the new value.

Source files
------------

// File: rtl/mult_hilo_unit_pkg.sv
// Shared types and constants for the iterative HI/LO multiplier.
package mult_hilo_unit_pkg;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_BUSY = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_t;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

endpackage

// File: rtl/mult_hilo_unit_datapath.sv
// Shift-add datapath: multiplicand, carry-extended accumulator, multiplier shift register, iteration counter.
// prod_next is the product as it will look after the current step, so the parent can capture it on the last edge.
module mult_hilo_unit_datapath #(
  parameter int WORD_LEN = 16,
  parameter int CNT_LEN  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic [WORD_LEN-1:0]     mcand_in,
  input  logic [WORD_LEN-1:0]     mplier_in,
  output logic [2*WORD_LEN-1:0]   prod_next,
  output logic                    last
);

  logic [WORD_LEN-1:0] mcand;
  logic [WORD_LEN-1:0] mplier;
  logic [WORD_LEN:0]   acc;
  logic [CNT_LEN-1:0]  cnt;

  logic [WORD_LEN:0]   sum;
  logic [WORD_LEN-1:0] acc_next;
  logic [WORD_LEN-1:0] mplier_next;

  always_comb begin
    sum         = acc + {1'b0, (mplier[0] ? mcand : {WORD_LEN{1'b0}})};
    // Right shift of {carry, acc, multiplier}: sum[0] drops into the multiplier's MSB.
    acc_next    = sum[WORD_LEN:1];
    mplier_next = {sum[0], mplier[WORD_LEN-1:1]};
    prod_next   = {acc_next, mplier_next};
    last        = (cnt == CNT_LEN'(WORD_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= {1'b0, acc_next};
      mplier <= mplier_next;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mult_hilo_unit.sv
// Multi-cycle MULT unit for the EXE stage: FSM, sign handling and HI/LO registers.
// Stalls the pipeline from issue until the result is written; done pulses in the cycle after.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int WORD_LEN = 16,
  parameter int CNT_LEN  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic [WORD_LEN-1:0] val1,
  input  logic [WORD_LEN-1:0] val2,
  input  logic                rd_sel,
  output logic [WORD_LEN-1:0] rd_data,
  output logic [WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0] lo,
  output logic                stall,
  output logic                done
);

  mult_state_t state;
  logic        neg;

  logic [WORD_LEN-1:0]   mag1;
  logic [WORD_LEN-1:0]   mag2;
  logic                  load;
  logic                  step;
  logic                  last;
  logic [2*WORD_LEN-1:0] prod_next;
  logic [2*WORD_LEN-1:0] result;

  always_comb begin
    // -(-2^(W-1)) wraps to 2^(W-1), which is the right magnitude when read unsigned.
    mag1   = (is_signed && val1[WORD_LEN-1]) ? -val1 : val1;
    mag2   = (is_signed && val2[WORD_LEN-1]) ? -val2 : val2;
    load   = (state == MULT_IDLE) && start;
    step   = (state == MULT_BUSY);
    result = neg ? -prod_next : prod_next;
  end

  mult_hilo_unit_datapath #(
    .WORD_LEN (WORD_LEN),
    .CNT_LEN  (CNT_LEN)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .mcand_in  (mag1),
    .mplier_in (mag2),
    .prod_next (prod_next),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MULT_IDLE;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        MULT_IDLE: begin
          done <= 1'b0;
          if (start) begin
            neg   <= is_signed & (val1[WORD_LEN-1] ^ val2[WORD_LEN-1]);
            state <= MULT_BUSY;
          end
        end
        MULT_BUSY: begin
          if (last) begin
            {hi, lo} <= result;
            done     <= 1'b1;
            state    <= MULT_DONE;
          end
        end
        MULT_DONE: begin
          // start is still the stalled MULT here; it must not retrigger.
          done  <= 1'b0;
          state <= MULT_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= MULT_IDLE;
        end
      endcase
    end
  end

  assign stall   = ((state == MULT_IDLE) && start) || (state == MULT_BUSY);
  assign rd_data = (rd_sel == HILO_SEL_HI) ? hi : lo;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: latency, products, back-to-back issue, reset abort, reads while busy.
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [15:0] val1;
  logic [15:0] val2;
  logic        rd_sel;
  logic [15:0] rd_data;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        stall;
  logic        done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mult_hilo_unit #(.WORD_LEN(16), .CNT_LEN(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .val1      (val1),
    .val2      (val2),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo),
    .stall     (stall),
    .done      (done)
  );

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a MULT at the current negedge and follow it to the done cycle.
  task automatic mult(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sgn,
                      input logic [15:0] ehi, input logic [15:0] elo, input bit release_start,
                      input bit chk_rd, input logic [15:0] old_rd);
    int n;
    n = 0;
    start = 1'b1; val1 = a; val2 = b; is_signed = sgn;
    #1;
    while (stall === 1'b1 && n < 40) begin
      if (chk_rd) check({tag, "_busy_rd"}, 32'(rd_data), 32'(old_rd));
      n++;
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd17);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hi"}, 32'(hi), 32'(ehi));
    check({tag, "_lo"}, 32'(lo), 32'(elo));
    if (chk_rd) check({tag, "_done_rd"}, 32'(rd_data), 32'(elo));
    if (release_start) begin
      start = 1'b0;
      @(negedge clk);
      check({tag, "_done_after"}, 32'(done), 32'd0);
      check({tag, "_stall_after"}, 32'(stall), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; val1 = '0; val2 = '0; rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", 32'(hi), 32'd0);
    check("rst_lo", 32'(lo), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    mult("u3x5", 16'd3, 16'd5, 1'b0, 16'h0000, 16'h000F, 1'b1, 1'b0, 16'h0);
    mult("umax", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 16'h0);
    rd_sel = 1'b1; #1;
    check("umax_rd_hi", 32'(rd_data), 32'h0000FFFE);
    rd_sel = 1'b0; #1;
    check("umax_rd_lo", 32'(rd_data), 32'h00000001);

    mult("s_m2x3", 16'hFFFE, 16'd3, 1'b1, 16'hFFFF, 16'hFFFA, 1'b1, 1'b0, 16'h0);
    mult("s_min", 16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0);

    // start stays high through DONE; the next MULT follows in the IDLE cycle.
    done_cnt = 0;
    mult("b2b_a", 16'd4, 16'd4, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0);
    val1 = 16'd7; val2 = 16'd9;
    @(negedge clk);
    mult("b2b_b", 16'd7, 16'd9, 1'b0, 16'h0000, 16'h003F, 1'b1, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    check("b2b_done_pulses", 32'(done_cnt), 32'd2);
    check("b2b_lo_final", 32'(lo), 32'h0000003F);

    // Reset in the 6th BUSY cycle discards the partial product.
    mult("pre17", 16'd17, 16'd1, 1'b0, 16'h0000, 16'h0011, 1'b1, 1'b0, 16'h0);
    start = 1'b1; val1 = 16'd3; val2 = 16'd5; is_signed = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("abort_busy_stall", 32'(stall), 32'd1);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("abort_hi", 32'(hi), 32'd0);
    check("abort_lo", 32'(lo), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_stall", 32'(stall), 32'd0);
    mult("post_rst", 16'd2, 16'd3, 1'b0, 16'h0000, 16'h0006, 1'b1, 1'b0, 16'h0);

    mult("pre17b", 16'd17, 16'd1, 1'b0, 16'h0000, 16'h0011, 1'b1, 1'b0, 16'h0);
    mult("rd_busy", 16'd3, 16'd5, 1'b0, 16'h0000, 16'h000F, 1'b1, 1'b1, 16'h0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
